// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the ROM read arbiter.
// Tags are sized for the largest supported requester count (8).
package rom_arb_pkg;

  localparam int unsigned MaxOutstandingDefault = 2;
  localparam int unsigned MaxNumReq             = 8;
  localparam int unsigned TagW                  = 3;

  typedef logic [TagW-1:0] tag_t;

  // Index width for a count of n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_arb_rr.sv
// Combinational round-robin picker: the first requester at or after rr_ptr_i wins.
module rom_arb_rr #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   rr_ptr_i,
  input  logic              en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic found;

  // Pass one covers [rr_ptr, NumReq), pass two wraps around to [0, rr_ptr).
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (en_i && !found && req_i[k] && (IdxW'(k) >= rr_ptr_i)) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IdxW'(k);
      end
    end
    for (int k = 0; k < NumReq; k++) begin
      if (en_i && !found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/rom_arb.sv
// Round-robin arbiter sharing one ROM among NumReq requesters; a tag FIFO routes
// each ROM response back to the requester that issued the read.
module rom_arb
  import rom_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned Width          = 32,
  parameter int unsigned Depth          = 2048,
  parameter int unsigned Aw             = $clog2(Depth),
  parameter int unsigned MaxOutstanding = MaxOutstandingDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_i,
  input  logic [NumReq*Aw-1:0] addr_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic [NumReq-1:0]    rvalid_o,
  output logic [Width-1:0]     rdata_o,
  output logic                 rom_cs_o,
  output logic [Aw-1:0]        rom_addr_o,
  input  logic [Width-1:0]     rom_rdata_i,
  input  logic                 rom_dvalid_i,
  output logic                 err_o
);

  localparam int unsigned IdxW = idx_w(NumReq);
  localparam int unsigned PtrW = idx_w(MaxOutstanding);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d, win_idx;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  tag_t            tags_q [MaxOutstanding];
  logic            err_q, err_d;
  logic            fifo_full, fifo_empty, push, pop, grant_en;

  assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = rom_dvalid_i & ~fifo_empty;
  // A pop in the same cycle frees the slot the new grant needs.
  assign grant_en   = ~fifo_full | pop;
  assign push       = |gnt_o;

  rom_arb_rr #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .en_i     (grant_en),
    .gnt_o    (gnt_o),
    .idx_o    (win_idx)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (rom_dvalid_i & fifo_empty);
    if (push) begin
      rr_ptr_d = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
      wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rom_addr_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (gnt_o[k]) rom_addr_o = addr_i[k*Aw +: Aw];
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      rvalid_o[k] = pop & (tags_q[rd_ptr_q] == tag_t'(k));
    end
  end

  assign rdata_o  = pop ? rom_rdata_i : '0;
  assign rom_cs_o = push;
  assign err_o    = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) tags_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push) tags_q[wr_ptr_q] <= tag_t'(win_idx);
    end
  end

endmodule
